// File: rtl/pulse_measure.sv
// pulse_measure: counts clk cycles from a trigger rise to a pulse rise, then the pulse high time.
// Define PULSE_MEASURE_PEAK_EN to add peakDelay/peakWidth running-maximum outputs.
module pulse_measure #(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic             pulse,
    input  logic             clearOverflow,
    output logic [NBITS-1:0] measuredDelay,
    output logic [NBITS-1:0] measuredWidth,
    output logic             measureValid,
    output logic             overflow,
`ifdef PULSE_MEASURE_PEAK_EN
    output logic [NBITS-1:0] peakDelay,
    output logic [NBITS-1:0] peakWidth,
`endif
    output logic [1:0]       dbg_state
);
    // measureValid is a one-cycle strobe with no ready: the consumer must take
    // measuredDelay/measuredWidth then or later, as they hold until the next strobe.

    localparam logic [NBITS-1:0] MAX    = {NBITS{1'b1}};
    localparam logic [NBITS-1:0] MAX_M1 = {{(NBITS-1){1'b1}}, 1'b0};
    localparam logic [NBITS-1:0] ONE    = {{(NBITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    state_t           state;
    logic             trig_prev;
    logic             pulse_prev;
    logic             pub_pending;
    logic [NBITS-1:0] delay_cnt;
    logic [NBITS-1:0] width_cnt;
    logic             trig_rise;
    logic             pulse_rise;
    logic             pulse_fall;
    logic             publish;

    assign trig_rise  = trigger & ~trig_prev;
    assign pulse_rise = pulse & ~pulse_prev;
    assign pulse_fall = ~pulse & pulse_prev;
    assign publish    = (state == S_HIGH) && pub_pending;
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            trig_prev     <= 1'b0;
            pulse_prev    <= 1'b0;
            pub_pending   <= 1'b0;
            delay_cnt     <= '0;
            width_cnt     <= '0;
            measuredDelay <= '0;
            measuredWidth <= '0;
            measureValid  <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            trig_prev    <= trigger;
            pulse_prev   <= pulse;
            measureValid <= 1'b0;
            // Clear is written first so any set below in the same cycle wins.
            if (clearOverflow) overflow <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (trig_rise) begin
                        delay_cnt   <= '0;
                        pub_pending <= 1'b0;
                        if (pulse_rise) begin
                            width_cnt <= ONE;
                            state     <= S_HIGH;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    // delay_cnt holds (edges since trigger rise) - 1; MAX marks an expired wait.
                    if (delay_cnt == MAX) begin
                        state <= S_IDLE;
                    end else if (pulse_rise) begin
                        delay_cnt <= delay_cnt + 1'b1;
                        width_cnt <= ONE;
                        state     <= S_HIGH;
                    end else begin
                        delay_cnt <= delay_cnt + 1'b1;
                        if (delay_cnt == MAX_M1) overflow <= 1'b1;
                    end
                end

                S_HIGH: begin
                    if (pub_pending) begin
                        measuredDelay <= delay_cnt;
                        measuredWidth <= width_cnt;
                        measureValid  <= 1'b1;
                        pub_pending   <= 1'b0;
                        state         <= S_IDLE;
                    end else if (pulse_fall) begin
                        pub_pending <= 1'b1;
                    end else if (pulse) begin
                        if (width_cnt == MAX) overflow <= 1'b1;
                        else                  width_cnt <= width_cnt + 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef PULSE_MEASURE_PEAK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peakDelay <= '0;
            peakWidth <= '0;
        end else if (publish) begin
            // A publish coinciding with clear restarts the maxima from the new result.
            if (clearOverflow || (delay_cnt > peakDelay)) peakDelay <= delay_cnt;
            if (clearOverflow || (width_cnt > peakWidth)) peakWidth <= width_cnt;
        end else if (clearOverflow) begin
            peakDelay <= '0;
            peakWidth <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_measure.sv
// tb_pulse_measure: directed and randomized delay/width scenarios for pulse_measure (NBITS=4)
// checked against a scenario-level reference model.
module tb_pulse_measure;
    localparam int NBITS = 4;
    localparam int MAX   = 15;
    localparam int EW    = 40;

    logic             clk;
    logic             reset;
    logic             trigger;
    logic             pulse;
    logic             clearOverflow;
    logic [NBITS-1:0] measuredDelay;
    logic [NBITS-1:0] measuredWidth;
    logic             measureValid;
    logic             overflow;
    logic [1:0]       dbg_state;
`ifdef PULSE_MEASURE_PEAK_EN
    logic [NBITS-1:0] peakDelay;
    logic [NBITS-1:0] peakWidth;
`endif

    pulse_measure #(.NBITS(NBITS)) dut (
        .clk           (clk),
        .reset         (reset),
        .trigger       (trigger),
        .pulse         (pulse),
        .clearOverflow (clearOverflow),
        .measuredDelay (measuredDelay),
        .measuredWidth (measuredWidth),
        .measureValid  (measureValid),
        .overflow      (overflow),
`ifdef PULSE_MEASURE_PEAK_EN
        .peakDelay     (peakDelay),
        .peakWidth     (peakWidth),
`endif
        .dbg_state     (dbg_state)
    );

    // clock / edge counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // scoreboard state: entries are {publish edge, delay, width}
    logic [EW-1:0] exp_q[$];
    int            tests = 0;
    int            fails = 0;
    bit            ovf_m = 1'b0;
    int            last_d = 0;
    int            last_w = 0;
    int            pk_d = 0;
    int            pk_w = 0;
    logic [EW-1:0] head;
    bit            exp_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_delay"}, measuredDelay, 0);
        check({tag, "_width"}, measuredWidth, 0);
        check({tag, "_valid"}, measureValid, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_state"}, dbg_state, 0);
`ifdef PULSE_MEASURE_PEAK_EN
        check({tag, "_peak_delay"}, peakDelay, 0);
        check({tag, "_peak_width"}, peakWidth, 0);
`endif
    endtask

    // One scenario: trigger rises at t=0 (edge kt), pulse high for edges [d, d+w).
    // d > MAX means the pulse never comes and the wait times out.
    task automatic meas(input int d, input int w, input bit retrig, input int gap);
        bit timeout;
        int last_t;
        int wm;
        int kt;
        timeout = (d > MAX);
        last_t  = timeout ? MAX + 2 : d + w + 1;
        wm      = (w > MAX) ? MAX : w;
        kt      = 0;
        for (int t = 0; t <= last_t; t++) begin
            trigger = (t < 2) || (retrig && (t == 4));
            pulse   = !timeout && (t >= d) && (t < d + w);
            step();
            if (t == 0) begin
                kt = cyc;
                if (!timeout) exp_q.push_back({32'(kt + d + w + 1), 4'(d), 4'(wm)});
            end
            if ((timeout && t == MAX) || (!timeout && w > MAX && t == d + MAX)) ovf_m = 1'b1;
            check("overflow", overflow, ovf_m);
        end
        trigger = 1'b0;
        pulse   = 1'b0;
        for (int g = 0; g < gap; g++) begin
            step();
            if (g == 0) check("missed_valid", exp_q.size(), 0);
        end
        check("idle_state", dbg_state, 0);
    endtask

    task automatic clear_ovf();
        clearOverflow = 1'b1;
        step();
        clearOverflow = 1'b0;
        ovf_m = 1'b0;
        pk_d  = 0;
        pk_w  = 0;
        check("overflow_clear", overflow, 0);
    endtask

    // monitor: strobe timing, held results and peak maxima every cycle
    always @(negedge clk) begin
        if (!reset) begin
            last_d = 0;
            last_w = 0;
            pk_d   = 0;
            pk_w   = 0;
        end else begin
            exp_valid = 1'b0;
            if (exp_q.size() > 0) begin
                head      = exp_q[0];
                exp_valid = (head[39:8] == 32'(cyc));
            end
            check("valid_strobe", measureValid, exp_valid);
            if (exp_valid) begin
                void'(exp_q.pop_front());
                last_d = int'(head[7:4]);
                last_w = int'(head[3:0]);
                if (last_d > pk_d) pk_d = last_d;
                if (last_w > pk_w) pk_w = last_w;
            end
            check("held_delay", measuredDelay, last_d);
            check("held_width", measuredWidth, last_w);
`ifdef PULSE_MEASURE_PEAK_EN
            check("peak_delay", peakDelay, pk_d);
            check("peak_width", peakWidth, pk_w);
`endif
        end
    end

    initial begin
        int d;
        int w;
        reset         = 1'b1;
        trigger       = 1'b0;
        pulse         = 1'b0;
        clearOverflow = 1'b0;
        #2 reset = 1'b0;
        #1;
        check_reset("por");
        @(negedge clk);
        #2 reset = 1'b1;

        meas(8, 7, 1'b0, 2);     // delay 8, width 7, strobe at kt+16
        meas(0, 1, 1'b0, 2);     // trigger and pulse rise together
        meas(20, 1, 1'b0, 2);    // no pulse: timeout sets overflow at kt+15
        clear_ovf();
        meas(2, 20, 1'b0, 2);    // width saturates at 15 and sets overflow
        meas(6, 3, 1'b1, 2);     // second trigger rise while waiting is ignored
        meas(1, 2, 1'b1, 2);     // trigger rise on the publish edge is lost

        // reset while HIGH aborts the measurement
        trigger = 1'b1;
        pulse   = 1'b1;
        step();
        trigger = 1'b0;
        step();
        step();
        #2 reset = 1'b0;
        #1;
        ovf_m = 1'b0;
        check_reset("mid_high_reset");
        pulse = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;

        // trigger already high when reset releases counts as a rise
        step();
        reset   = 1'b0;
        trigger = 1'b1;
        #1;
        check_reset("reset_trig_high");
        @(negedge clk);
        #2 reset = 1'b1;
        meas(3, 2, 1'b0, 2);

        // running maxima across two measurements
        clear_ovf();
        meas(3, 5, 1'b0, 2);
        meas(7, 2, 1'b0, 2);
`ifdef PULSE_MEASURE_PEAK_EN
        check("peak_delay_pair", peakDelay, 7);
        check("peak_width_pair", peakWidth, 5);
`endif

        for (int i = 0; i < 30; i++) begin
            d = $urandom_range(0, 17);
            w = $urandom_range(1, 18);
            meas(d, w, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) clear_ovf();
        end

        step();
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
